// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle restoring divider, signed/unsigned, start/done handshake
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request; in1/in2/sgn sampled when accepted (IDLE or DONE)
//   sgn    1 = two's-complement signed, 0 = unsigned
//   in1    dividend
//   in2    divisor
//   busy   high while iterating; start is ignored
//   done   one-cycle pulse; out/rem/dbz valid from this cycle
//   out    quotient
//   rem    remainder
//   dbz    divide-by-zero flag for the current result
module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_LAST = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
  logic [WIDTH-1:0] prem_q, prem_d;  // restored partial remainder (always < divisor)
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;         // WIDTH+1-bit partial remainder after the shift
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    accept = start && (state_q != CALC);
    a_mag  = (sgn && in1[WIDTH-1]) ? -in1 : in1;
    b_mag  = (sgn && in2[WIDTH-1]) ? -in2 : in2;

    // diff cannot exceed the WIDTH+1-bit signed range because shifted < 2*divisor,
    // so its top bit is a reliable "subtraction went negative" flag. When restoring,
    // shifted < divisor, so dropping its top bit loses nothing.
    shifted = {prem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    r_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    q_step  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (in2 == '0) begin
            state_d = DONE;
            out_d   = '1;
            rem_d   = in1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            prem_d  = '0;
            cnt_d   = '0;
            negq_d  = sgn && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            negr_d  = sgn && in1[WIDTH-1];
          end
        end
      end
      CALC: begin
        quo_d  = q_step;
        prem_d = r_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST[WIDTH-1:0]) begin
          state_d = DONE;
          // -2^(W-1) / -1 yields magnitude 2^(W-1), which already reads as -2^(W-1)
          out_d   = negq_q ? -q_step : q_step;
          rem_d   = negr_q ? -r_step : r_step;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign out  = out_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule
